data_cache: RTL



---
 rtl/data_cache_pkg.sv | 10 +
 rtl/data_cache_line_store.sv | 39 +++
 rtl/data_cache.sv | 89 ++++++++
 3 files changed

// File: rtl/data_cache_pkg.sv
// data_cache_pkg: FSM state encoding and a saturating counter helper shared by the data cache.
package data_cache_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/data_cache_line_store.sv
// dcache_line_store: valid/tag/data arrays with combinational read, whole-line fill and single-word write.
module dcache_line_store #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_LINES  = 8,
  parameter int TAG_BITS   = 27,
  parameter int IB         = $clog2(NUM_LINES),
  parameter int OB         = $clog2(BLOCK_SIZE)
)(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [IB-1:0]                    index,
  output logic                             rd_valid,
  output logic [TAG_BITS-1:0]              rd_tag,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0]  rd_line,
  input  logic                             fill_en,
  input  logic [TAG_BITS-1:0]              fill_tag,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0]  fill_line,
  input  logic                             wr_en,
  input  logic [OB-1:0]                    wr_offset,
  input  logic [WORD_SIZE-1:0]             wr_data
);
  logic [NUM_LINES-1:0]            valid;
  logic [TAG_BITS-1:0]             tags  [NUM_LINES];
  logic [WORD_SIZE*BLOCK_SIZE-1:0] lines [NUM_LINES];
  assign rd_valid = valid[index];
  assign rd_tag   = tags[index];
  assign rd_line  = lines[index];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid <= '0;
    else if (fill_en) valid[index] <= 1'b1;
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[index]  <= fill_tag;
      lines[index] <= fill_line;
    end
    if (wr_en) lines[index][wr_offset*WORD_SIZE +: WORD_SIZE] <= wr_data;
  end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-through no-write-allocate cache in front of data_memory.
// Define DCACHE_PERF_COUNTERS_EN to add saturating read hit/miss counters.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_SIZE  = 4,
  parameter int NUM_LINES   = 8,
  parameter int MEM_LATENCY = 1
)(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  input  logic                            req_write,
  input  logic [WORD_SIZE-1:0]            req_addr,
  input  logic [WORD_SIZE-1:0]            req_wdata,
  output logic                            req_ready,
  output logic                            resp_valid,
  output logic [WORD_SIZE-1:0]            resp_rdata,
  output logic [WORD_SIZE-1:0]            mem_ptr,
  output logic [WORD_SIZE-1:0]            mem_val,
  output logic                            mem_write_enable,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_out_block
`ifdef DCACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]                     hit_count,
  output logic [31:0]                     miss_count
`endif
);
  localparam int OB = $clog2(BLOCK_SIZE);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TB = WORD_SIZE - OB - IB;
  logic [1:0]                      state;
  logic [3:0]                      cnt;
  logic [WORD_SIZE-1:0]            lat_addr, addr, word;
  logic                            rd_valid, hit, accept, fill_done, rd_hit;
  logic [TB-1:0]                   rd_tag;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] rd_line;
  // Lookups use the live request in IDLE and the latched request everywhere else.
  assign addr      = state == IDLE ? req_addr : lat_addr;
  assign hit       = rd_valid && rd_tag == addr[WORD_SIZE-1 -: TB];
  assign word      = rd_line[addr[OB-1:0]*WORD_SIZE +: WORD_SIZE];
  assign req_ready = state == IDLE;
  assign accept    = req_valid && req_ready;
  assign rd_hit    = accept && !req_write && hit;
  assign fill_done = state == FILL && cnt == 4'(MEM_LATENCY - 1);
  dcache_line_store #(
    .WORD_SIZE(WORD_SIZE), .BLOCK_SIZE(BLOCK_SIZE), .NUM_LINES(NUM_LINES), .TAG_BITS(TB)
  ) u_store (
    .clk(clk), .rst_n(rst_n), .index(addr[OB +: IB]),
    .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_line(rd_line),
    .fill_en(fill_done), .fill_tag(addr[WORD_SIZE-1 -: TB]), .fill_line(mem_out_block),
    .wr_en(state == WRITE && hit), .wr_offset(addr[OB-1:0]), .wr_data(mem_val)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      lat_addr         <= '0;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      mem_ptr          <= '0;
      mem_val          <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      resp_valid       <= rd_hit || state == RESP || state == WRITE;
      resp_rdata       <= (rd_hit || state == RESP) ? word : '0;
      mem_write_enable <= accept && req_write;
      cnt              <= state == FILL ? cnt + 4'd1 : 4'd0;
      state            <= accept ? (req_write ? WRITE : hit ? IDLE : FILL)
                        : state == FILL ? (fill_done ? RESP : FILL)
                        : IDLE;
      if (accept) begin
        lat_addr <= req_addr;
        mem_ptr  <= req_write ? req_addr : req_addr & ~WORD_SIZE'(BLOCK_SIZE - 1);
        if (req_write) mem_val <= req_wdata;
      end
    end
`ifdef DCACHE_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept && !req_write) begin
      if (hit) hit_count <= sat_inc(hit_count);
      else miss_count <= sat_inc(miss_count);
    end
`endif
endmodule
